// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: the hazard sequencer state and the per-latch
// enable/flush pair that drives each pipeline register.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN,
        DSTALL,
        HALTED
    } hzd_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t SC_HOLD  = '{en: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t SC_ADV   = '{en: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t SC_FLUSH = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/perf_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module perf_counter #(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            inc,
    output logic [CNTW-1:0] cnt
);

    logic [CNTW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: PC enable, latch en/flush,
// sticky halt, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic [REGW-1:0] ifid_rs,
    input  logic [REGW-1:0] ifid_rt,
    input  logic            idex_dREN,
    input  logic [REGW-1:0] idex_rt,
    input  logic            exmem_dREN,
    input  logic            exmem_dWEN,
    input  logic            exmem_pcsrc,
    input  logic            memwb_halt,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            memwb_flush,
    output logic            halt,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    hzd_state_t  state_d, state_q;
    logic        halt_d, halt_q;
    logic        dreq, loaduse;
    logic        adv_pc, adv_redirect;
    stage_ctrl_t adv_ifid, adv_idex, adv_exmem, adv_memwb;
    logic        pc_en_c, redirect;
    stage_ctrl_t ifid_c, idex_c, exmem_c, memwb_c;

    assign dreq    = exmem_dREN | exmem_dWEN;
    assign loaduse = idex_dREN && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // Advance pattern, shared by RUN and the dhit cycle that ends a DSTALL.
    always_comb begin
        adv_pc       = 1'b1;
        adv_redirect = 1'b0;
        adv_ifid     = SC_ADV;
        adv_idex     = SC_ADV;
        adv_exmem    = SC_ADV;
        adv_memwb    = SC_ADV;
        if (exmem_pcsrc) begin
            adv_redirect = 1'b1;
            adv_ifid     = SC_FLUSH;
            adv_idex     = SC_FLUSH;
            adv_exmem    = SC_FLUSH;
        end else if (loaduse) begin
            adv_pc   = 1'b0;
            adv_ifid = SC_HOLD;
            adv_idex = SC_FLUSH;
        end else if (!ihit) begin
            adv_pc   = 1'b0;
            adv_ifid = SC_FLUSH;
        end
    end

    always_comb begin
        state_d  = state_q;
        halt_d   = halt_q;
        pc_en_c  = 1'b0;
        redirect = 1'b0;
        ifid_c   = SC_HOLD;
        idex_c   = SC_HOLD;
        exmem_c  = SC_HOLD;
        memwb_c  = SC_HOLD;
        if (RST) begin
            state_d = RUN;
            halt_d  = 1'b0;
            ifid_c  = SC_FLUSH;
            idex_c  = SC_FLUSH;
            exmem_c = SC_FLUSH;
            memwb_c = SC_FLUSH;
        end else if (memwb_halt) begin
            state_d = HALTED;
            halt_d  = 1'b1;
        end else begin
            case (state_q)
                RUN, DSTALL: begin
                    // A waiting D-access freezes the pipe and bubbles MEM/WB.
                    if ((state_q == DSTALL || dreq) && !dhit) begin
                        state_d = DSTALL;
                        memwb_c = SC_FLUSH;
                    end else begin
                        state_d  = RUN;
                        pc_en_c  = adv_pc;
                        redirect = adv_redirect;
                        ifid_c   = adv_ifid;
                        idex_c   = adv_idex;
                        exmem_c  = adv_exmem;
                        memwb_c  = adv_memwb;
                    end
                end
                HALTED:  halt_d  = 1'b1;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    perf_counter #(.CNTW(CNTW)) u_stall_cnt (
        .clk (CLK),
        .clr (RST),
        .inc (!pc_en_c && (state_q != HALTED)),
        .cnt (stall_cnt)
    );

    perf_counter #(.CNTW(CNTW)) u_flush_cnt (
        .clk (CLK),
        .clr (RST),
        .inc (redirect),
        .cnt (flush_cnt)
    );

    assign pc_en       = pc_en_c;
    assign ifid_en     = ifid_c.en;
    assign ifid_flush  = ifid_c.flush;
    assign idex_en     = idex_c.en;
    assign idex_flush  = idex_c.flush;
    assign exmem_en    = exmem_c.en;
    assign exmem_flush = exmem_c.flush;
    assign memwb_en    = memwb_c.en;
    assign memwb_flush = memwb_c.flush;
    assign halt        = halt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the PC enable and the en/flush pair of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, taken branches/jumps, I-cache and D-cache waits, and the processor halt. It also keeps saturating stall and flush performance counters for the datapath top level.

Parameters:
- REGW, 5, register-index width.
- CNTW, 16, width of each performance counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  I-memory fetch complete this cycle.
- dhit  in  1  D-memory access complete this cycle.
- ifid_rs  in  REGW  rs field of the instruction in ID.
- ifid_rt  in  REGW  rt field of the instruction in ID.
- idex_dREN  in  1  the instruction in EX is a load.
- idex_rt  in  REGW  destination of the load in EX.
- exmem_dREN  in  1  the instruction in MEM is a load.
- exmem_dWEN  in  1  the instruction in MEM is a store.
- exmem_pcsrc  in  1  the instruction in MEM redirects the PC (taken branch, J, JAL, JR).
- memwb_halt  in  1  a HALT has reached WB.
- pc_en  out  1  PC register load enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch clears (bubble insert).
- halt  out  1  registered, sticky halt to the system.
- stall_cnt  out  CNTW  cycles in which pc_en was 0 while not halted.
- flush_cnt  out  CNTW  redirect flush events.

Behaviour:
- FSM states are RUN, DSTALL and HALTED. The state register resets to RUN. halt resets to 0. Both counters reset to 0.
- While RST is high: every en is 0 and every flush is 1.
- A latch must not see flush=1 and en=1 in the same cycle unless flush is meant to win. The latches give flush priority.
- dreq = exmem_dREN | exmem_dWEN.
- loaduse = idex_dREN & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
- RUN: apply the first matching rule, in this order.
  1. dreq & !dhit: all en = 0, memwb_flush = 1, other flushes 0. Next state is DSTALL.
  2. exmem_pcsrc: pc_en = 1, ifid_flush = idex_flush = exmem_flush = 1, memwb_en = 1. flush_cnt increments by 1. This rule applies even if ihit = 0; the pending fetch is abandoned.
  3. loaduse: pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en = memwb_en = 1.
  4. !ihit: pc_en = 0, ifid_flush = 1, idex_en = exmem_en = memwb_en = 1.
  5. Otherwise: every en = 1, every flush = 0.
- DSTALL:
  - While dhit = 0: hold as in rule 1.
  - On dhit = 1: all latches advance exactly as in RUN rules 2-5, evaluated with the current inputs. Next state is RUN.
  - The D-cache access is never re-issued. exmem_pcsrc held in a frozen EX/MEM is honoured on the dhit cycle.
- memwb_halt = 1, in any state, has top priority:
  - Next state is HALTED. halt becomes 1 on the next edge.
  - All en = 0 on that cycle and thereafter.
- HALTED: all en = 0, all flush = 0, halt = 1. The FSM leaves HALTED only on RST.
- Counters:
  - stall_cnt increments on every cycle with pc_en = 0 and state != HALTED.
  - Both counters saturate at all-ones and do not wrap.
- All enable/flush outputs are combinational from state plus inputs, with zero latency. Only state, halt and the counters are registered.
- RST asserted mid-stall or in HALTED returns to RUN on the next edge. Counters clear on that edge.
- A load-use whose rs and rt are both the load target counts as one stall, not two.

Decomposition:
- Shared cpu_types_pkg gains the enum hzd_state_t {RUN, DSTALL, HALTED}.
- Shared cpu_types_pkg gains the struct stage_ctrl_t {en, flush}. Each latch gets one stage_ctrl_t.
- Sub-module perf_counter (CNTW parameter, inc input, synchronous clear, saturating) is instantiated twice.

Test Plan:
- Reset, then no hazards, ihit = dhit = 1: after RST drops, every en = 1, every flush = 0, pc_en = 1, and both counters stay 0.
- Load-use: idex_dREN = 1, idex_rt = 8, ifid_rs = 8 for one cycle. Required: pc_en = 0, ifid_en = 0, idex_flush = 1 for that cycle, then stall_cnt = 1.
- Load-use against $zero: idex_rt = 0, ifid_rt = 0. Required: no stall, pc_en = 1.
- D-miss: exmem_dREN = 1 with dhit low for 3 cycles, then high. Required:
  - DSTALL for 3 cycles with all en = 0 and memwb_flush = 1.
  - On the dhit cycle, everything advances.
  - stall_cnt = 3 afterwards; the dhit cycle is not counted since pc_en = 1.
- Branch during D-miss: exmem_pcsrc = 1 and exmem_dWEN = 1 with dhit low for 2 cycles. Required:
  - No flush during the 2 stall cycles.
  - On the dhit cycle, ifid_flush = idex_flush = exmem_flush = 1.
  - flush_cnt = 1.
- Halt: memwb_halt pulses while ihit = 0. Required:
  - halt = 1 on the next edge and stays 1 with inputs toggled.
  - All en = 0.
  - RST returns state to RUN and clears halt and both counters.
